// File: rtl/as_sdc_initiator.sv
// ---------------------------------------------------------------------------
// as_sdc_initiator
//
// Autonomous-system side of the shutdown-circuit (SDC) closing interface.
// Turns the AS computer heartbeat into a toggling Watchdog feed, sequences
// the AS_close_SDC request once the SDC logic reports ready, supervises the
// relay feedback, and latches a fault code on any protocol violation.
//
// Ports:
//   clk               in   system clock, all inputs synchronous to it
//   Power_on_Reset    in   asynchronous active-high reset
//   AS_Heartbeat      in   one-cycle heartbeat pulse from the AS computer
//   AS_Close_Request  in   level, AS requests SDC closure
//   AS_Open_Request   in   level, AS requests return to IDLE
//   Fault_Clear       in   pulse, clears a latched fault (FAULT state only)
//   SDC_is_Ready      in   ready indication from the SDC logic
//   To_SDC_relais_fb  in   SDC relay drive feedback
//   Watchdog          out  watchdog square-wave feed
//   AS_close_SDC      out  close request to the SDC logic
//   State             out  FSM state (0 IDLE,1 WAIT_READY,2 CLOSING,3 CLOSED,4 FAULT)
//   SDC_Fault         out  latched fault flag
//   Fault_Code        out  latched fault cause (1 ready timeout, 2 relay
//                          timeout, 3 relay drop, 4 heartbeat lost)
// ---------------------------------------------------------------------------
module as_sdc_initiator #(
   parameter int unsigned WD_HALF_PERIOD = 500,
   parameter int unsigned HB_TIMEOUT     = 2000,
   parameter int unsigned READY_DEBOUNCE = 16,
   parameter int unsigned CLOSE_TIMEOUT  = 1000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic       clk,
   input  logic       Power_on_Reset,
   input  logic       AS_Heartbeat,
   input  logic       AS_Close_Request,
   input  logic       AS_Open_Request,
   input  logic       Fault_Clear,
   input  logic       SDC_is_Ready,
   input  logic       To_SDC_relais_fb,
   output logic       Watchdog,
   output logic       AS_close_SDC,
   output logic [2:0] State,
   output logic       SDC_Fault,
   output logic [2:0] Fault_Code
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_READY = 3'd1,
      ST_CLOSING    = 3'd2,
      ST_CLOSED     = 3'd3,
      ST_FAULT      = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      FC_NONE       = 3'd0,
      FC_READY_TO   = 3'd1,
      FC_RELAY_TO   = 3'd2,
      FC_RELAY_DROP = 3'd3,
      FC_HB_LOST    = 3'd4
   } fault_t;

   localparam logic [CNT_W-1:0] C_HB_MAX   = CNT_W'(HB_TIMEOUT);
   localparam logic [CNT_W-1:0] C_WD_LAST  = CNT_W'(WD_HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] C_RDY_LAST = CNT_W'(READY_DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(CLOSE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

   state_t           r_state;
   fault_t           r_code;
   logic [CNT_W-1:0] r_hb_cnt;
   logic [CNT_W-1:0] r_wd_cnt;
   logic [CNT_W-1:0] r_st_cnt;
   logic [CNT_W-1:0] r_rdy_cnt;
   logic             r_watchdog;
   logic             r_close;
   logic             r_fault;

   state_t           w_next_state;
   fault_t           w_next_code;
   logic             w_hb_ok;
   logic             w_wd_run;
   logic             w_timeout;
   logic             w_rdy_hit;

   assign w_hb_ok   = (r_hb_cnt < C_HB_MAX);
   assign w_wd_run  = w_hb_ok && (r_state != ST_FAULT);
   assign w_timeout = (r_st_cnt >= C_TO_LAST);
   assign w_rdy_hit = SDC_is_Ready && (r_rdy_cnt >= C_RDY_LAST);

   // -----------------------------------------------------------------------
   // Heartbeat supervision. Starts saturated so the heartbeat only counts as
   // present once the first pulse has been seen after reset.
   // -----------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge Power_on_Reset) begin
      if (Power_on_Reset) begin
         r_hb_cnt <= C_HB_MAX;
      end else if (AS_Heartbeat) begin
         r_hb_cnt <= '0;
      end else if (r_hb_cnt < C_HB_MAX) begin
         r_hb_cnt <= r_hb_cnt + 1'b1;
      end
   end

   // -----------------------------------------------------------------------
   // Watchdog square wave. Restarting from wd_cnt=0 with Watchdog=0 makes the
   // first rising edge land exactly one half-period after the restart.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge Power_on_Reset) begin
      if (Power_on_Reset) begin
         r_wd_cnt   <= '0;
         r_watchdog <= 1'b0;
      end else if (!w_wd_run) begin
         r_wd_cnt   <= '0;
         r_watchdog <= 1'b0;
      end else if (r_wd_cnt == C_WD_LAST) begin
         r_wd_cnt   <= '0;
         r_watchdog <= ~r_watchdog;
      end else begin
         r_wd_cnt   <= r_wd_cnt + 1'b1;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state logic. Priority inside the active states: heartbeat loss,
   // then timeout / relay drop, then open request, then normal progress.
   // -----------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_next_code  = FC_NONE;
      case (r_state)
         ST_IDLE: begin
            if (AS_Close_Request && w_hb_ok) begin
               w_next_state = ST_WAIT_READY;
            end
         end
         ST_WAIT_READY: begin
            if (!w_hb_ok) begin
               w_next_state = ST_FAULT;
               w_next_code  = FC_HB_LOST;
            end else if (w_timeout) begin
               w_next_state = ST_FAULT;
               w_next_code  = FC_READY_TO;
            end else if (AS_Open_Request || !AS_Close_Request) begin
               w_next_state = ST_IDLE;
            end else if (w_rdy_hit) begin
               w_next_state = ST_CLOSING;
            end
         end
         ST_CLOSING: begin
            if (!w_hb_ok) begin
               w_next_state = ST_FAULT;
               w_next_code  = FC_HB_LOST;
            end else if (w_timeout) begin
               w_next_state = ST_FAULT;
               w_next_code  = FC_RELAY_TO;
            end else if (AS_Open_Request) begin
               w_next_state = ST_IDLE;
            end else if (To_SDC_relais_fb) begin
               w_next_state = ST_CLOSED;
            end
         end
         ST_CLOSED: begin
            if (!w_hb_ok) begin
               w_next_state = ST_FAULT;
               w_next_code  = FC_HB_LOST;
            end else if (!To_SDC_relais_fb && !AS_Open_Request) begin
               w_next_state = ST_FAULT;
               w_next_code  = FC_RELAY_DROP;
            end else if (AS_Open_Request) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (Fault_Clear && !AS_Close_Request && w_hb_ok) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // State register, per-state counters and registered outputs. Outputs are
   // decoded from the next state so they change on the same edge as State.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge Power_on_Reset) begin
      if (Power_on_Reset) begin
         r_state   <= ST_IDLE;
         r_st_cnt  <= '0;
         r_rdy_cnt <= '0;
         r_close   <= 1'b0;
         r_fault   <= 1'b0;
         r_code    <= FC_NONE;
      end else begin
         r_state <= w_next_state;

         if (w_next_state != r_state) begin
            r_st_cnt <= '0;
         end else if (r_st_cnt != C_CNT_MAX) begin
            r_st_cnt <= r_st_cnt + 1'b1;
         end

         // Ready debounce only accumulates while staying in WAIT_READY.
         if ((r_state == ST_WAIT_READY) && (w_next_state == ST_WAIT_READY)
             && SDC_is_Ready) begin
            if (r_rdy_cnt != C_CNT_MAX) begin
               r_rdy_cnt <= r_rdy_cnt + 1'b1;
            end
         end else begin
            r_rdy_cnt <= '0;
         end

         r_close <= (w_next_state == ST_CLOSING);
         r_fault <= (w_next_state == ST_FAULT);

         // The cause is captured on entry to FAULT and frozen until it leaves.
         if ((r_state != ST_FAULT) && (w_next_state == ST_FAULT)) begin
            r_code <= w_next_code;
         end else if (w_next_state != ST_FAULT) begin
            r_code <= FC_NONE;
         end
      end
   end

   assign Watchdog     = r_watchdog;
   assign AS_close_SDC = r_close;
   assign State        = r_state;
   assign SDC_Fault    = r_fault;
   assign Fault_Code   = r_code;

endmodule

// File: tb/tb_as_sdc_initiator.sv
// ---------------------------------------------------------------------------
// tb_as_sdc_initiator
//
// Self-checking bench for as_sdc_initiator with small parameters
// (WD_HALF_PERIOD=4, HB_TIMEOUT=10, READY_DEBOUNCE=3, CLOSE_TIMEOUT=20).
// A table of hand-derived vectors covers the main close/fault/clear flow,
// short directed sequences cover the multi-cycle corners, and a random phase
// compares every cycle against a behavioural model kept in this file.
// ---------------------------------------------------------------------------
module tb_as_sdc_initiator;

   localparam int WD = 4;
   localparam int HB = 10;
   localparam int RD = 3;
   localparam int CT = 20;

   logic       clk = 1'b0;
   logic       Power_on_Reset;
   logic       AS_Heartbeat;
   logic       AS_Close_Request;
   logic       AS_Open_Request;
   logic       Fault_Clear;
   logic       SDC_is_Ready;
   logic       To_SDC_relais_fb;
   logic       Watchdog;
   logic       AS_close_SDC;
   logic [2:0] State;
   logic       SDC_Fault;
   logic [2:0] Fault_Code;

   int n_checks = 0;
   int n_fail   = 0;

   as_sdc_initiator #(
      .WD_HALF_PERIOD(WD),
      .HB_TIMEOUT    (HB),
      .READY_DEBOUNCE(RD),
      .CLOSE_TIMEOUT (CT),
      .CNT_W         (16)
   ) dut (
      .clk             (clk),
      .Power_on_Reset  (Power_on_Reset),
      .AS_Heartbeat    (AS_Heartbeat),
      .AS_Close_Request(AS_Close_Request),
      .AS_Open_Request (AS_Open_Request),
      .Fault_Clear     (Fault_Clear),
      .SDC_is_Ready    (SDC_is_Ready),
      .To_SDC_relais_fb(To_SDC_relais_fb),
      .Watchdog        (Watchdog),
      .AS_close_SDC    (AS_close_SDC),
      .State           (State),
      .SDC_Fault       (SDC_Fault),
      .Fault_Code      (Fault_Code)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Behavioural model: tracks elapsed times as plain integers
   // (cycles since heartbeat, cycles spent in the state, consecutive ready
   // samples, edges the watchdog has been running) and derives outputs.
   // ------------------------------------------------------------------------
   int m_state, m_since_hb, m_in_state, m_ready_run, m_wd_edges;
   int m_code;
   bit m_wd, m_fault, m_close;

   task automatic model_reset();
      m_state     = 0;
      m_since_hb  = HB;
      m_in_state  = 0;
      m_ready_run = 0;
      m_wd_edges  = 0;
      m_code      = 0;
      m_wd        = 1'b0;
      m_fault     = 1'b0;
      m_close     = 1'b0;
   endtask

   task automatic model_step(input bit hb, input bit close, input bit open,
                             input bit clr, input bit rdy, input bit fb);
      bit alive     = (m_since_hb < HB);
      bit expired   = (m_in_state + 1 >= CT);       // CT-th edge in this state
      bit ready_ok  = rdy && (m_ready_run + 1 >= RD); // RD-th consecutive ready
      int nxt       = m_state;
      int cause     = 0;
      if (m_state inside {1, 2, 3} && !alive) begin
         nxt = 4; cause = 4;
      end else begin
         case (m_state)
            0: if (close && alive) nxt = 1;
            1: if (expired) begin nxt = 4; cause = 1; end
               else if (open || !close) nxt = 0;
               else if (ready_ok) nxt = 2;
            2: if (expired) begin nxt = 4; cause = 2; end
               else if (open) nxt = 0;
               else if (fb) nxt = 3;
            3: if (!fb && !open) begin nxt = 4; cause = 3; end
               else if (open) nxt = 0;
            4: if (clr && !close && alive) nxt = 0;
            default: nxt = 0;
         endcase
      end
      if (alive && m_state != 4) begin
         m_wd_edges++;
         m_wd = ((m_wd_edges / WD) % 2) == 1;
      end else begin
         m_wd_edges = 0;
         m_wd       = 1'b0;
      end
      m_ready_run = (m_state == 1 && nxt == 1 && rdy) ? m_ready_run + 1 : 0;
      m_in_state  = (nxt != m_state) ? 0 : m_in_state + 1;
      if (nxt == 4 && m_state != 4) m_code = cause;
      else if (nxt != 4)            m_code = 0;
      m_fault    = (nxt == 4);
      m_close    = (nxt == 2);
      m_state    = nxt;
      m_since_hb = hb ? 0 : ((m_since_hb < HB) ? m_since_hb + 1 : m_since_hb);
   endtask

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs are applied, the model advanced, then outputs are sampled 1 time
   // unit after the active edge.
   task automatic step(input bit hb, input bit close, input bit open,
                       input bit clr, input bit rdy, input bit fb);
      AS_Heartbeat     = hb;
      AS_Close_Request = close;
      AS_Open_Request  = open;
      Fault_Clear      = clr;
      SDC_is_Ready     = rdy;
      To_SDC_relais_fb = fb;
      model_step(hb, close, open, clr, rdy, fb);
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at a falling edge with reset released.
   task automatic do_reset();
      AS_Heartbeat     = 1'b0;
      AS_Close_Request = 1'b0;
      AS_Open_Request  = 1'b0;
      Fault_Clear      = 1'b0;
      SDC_is_Ready     = 1'b0;
      To_SDC_relais_fb = 1'b0;
      Power_on_Reset   = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      Power_on_Reset = 1'b0;
      model_reset();
   endtask

   // Heartbeat every cycle; IDLE -> WAIT_READY -> CLOSING on the 5th edge.
   task automatic enter_closing();
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      repeat (3) step(1, 1, 0, 0, 1, 0);
   endtask

   typedef struct {
      logic [5:0] in;   // {hb, close, open, clr, rdy, fb}
      logic [2:0] st;
      logic       csdc;
      logic       wd;
      logic       flt;
      logic [2:0] code;
   } vec_t;

   function automatic vec_t mk(input logic [5:0] in, input logic [2:0] st,
                               input logic csdc, input logic wd,
                               input logic flt, input logic [2:0] code);
      vec_t v;
      v.in = in; v.st = st; v.csdc = csdc; v.wd = wd; v.flt = flt; v.code = code;
      return v;
   endfunction

   vec_t vecs[12];

   initial begin
      logic [8:0] exp_bundle;
      logic [8:0] act_bundle;
      bit         r_hb, r_close, r_open, r_clr, r_rdy, r_fb;

      // Main flow: heartbeat, close sequence, relay drop fault, clear.
      //               hb c o clr r fb    st    csdc  wd    flt   code
      vecs[0]  = mk(6'b100000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
      vecs[1]  = mk(6'b010000, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0);
      vecs[2]  = mk(6'b010010, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0);
      vecs[3]  = mk(6'b010010, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0);
      vecs[4]  = mk(6'b010010, 3'd2, 1'b1, 1'b1, 1'b0, 3'd0);
      vecs[5]  = mk(6'b110010, 3'd2, 1'b1, 1'b1, 1'b0, 3'd0);
      vecs[6]  = mk(6'b010011, 3'd3, 1'b0, 1'b1, 1'b0, 3'd0);
      vecs[7]  = mk(6'b010010, 3'd4, 1'b0, 1'b1, 1'b1, 3'd3);
      vecs[8]  = mk(6'b010100, 3'd4, 1'b0, 1'b0, 1'b1, 3'd3);
      vecs[9]  = mk(6'b100000, 3'd4, 1'b0, 1'b0, 1'b1, 3'd3);
      vecs[10] = mk(6'b000100, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
      vecs[11] = mk(6'b000000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);

      Power_on_Reset = 1'b1;
      model_reset();
      do_reset();
      check("reset_state", 16'(State), 16'd0);
      check("reset_outputs", 16'({Watchdog, AS_close_SDC, SDC_Fault, Fault_Code}), 16'd0);

      for (int i = 0; i < 12; i++) begin
         step(vecs[i].in[5], vecs[i].in[4], vecs[i].in[3],
              vecs[i].in[2], vecs[i].in[1], vecs[i].in[0]);
         check($sformatf("vec%0d_state", i), 16'(State), 16'(vecs[i].st));
         check($sformatf("vec%0d_close_sdc", i), 16'(AS_close_SDC), 16'(vecs[i].csdc));
         check($sformatf("vec%0d_watchdog", i), 16'(Watchdog), 16'(vecs[i].wd));
         check($sformatf("vec%0d_sdc_fault", i), 16'(SDC_Fault), 16'(vecs[i].flt));
         check($sformatf("vec%0d_fault_code", i), 16'(Fault_Code), 16'(vecs[i].code));
      end

      // No heartbeat yet after reset: close request must not be accepted and
      // the watchdog stays low. Then heartbeat every 5 cycles: first rise
      // 4 cycles after the first pulse, toggling every 4 cycles after that.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 0, 0, 0, 0);
         check($sformatf("nohb_state%0d", k), 16'(State), 16'd0);
         check($sformatf("nohb_wd%0d", k), 16'(Watchdog), 16'd0);
      end
      for (int k = 0; k <= 24; k++) begin
         step((k % 5) == 0, 0, 0, 0, 0, 0);
         check($sformatf("wd_period_k%0d", k), 16'(Watchdog), 16'(((k / WD) % 2)));
      end

      // Ready pattern 1,1,0,1,1,1: CLOSING only after the last three 1s.
      do_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      check("rdy_pat_wait", 16'(State), 16'd1);
      begin
         bit         pat[6] = '{1, 1, 0, 1, 1, 1};
         logic [2:0] exp_st[6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
         for (int k = 0; k < 6; k++) begin
            step(1, 1, 0, 0, pat[k], 0);
            check($sformatf("rdy_pat_state%0d", k), 16'(State), 16'(exp_st[k]));
         end
         check("rdy_pat_close_sdc", 16'(AS_close_SDC), 16'd1);
      end

      // Ready held low for CLOSE_TIMEOUT cycles -> FAULT, code 1.
      do_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      repeat (CT - 1) step(1, 1, 0, 0, 0, 0);
      check("rdy_to_before", 16'(State), 16'd1);
      step(1, 1, 0, 0, 0, 0);
      check("rdy_to_state", 16'(State), 16'd4);
      check("rdy_to_code", 16'(Fault_Code), 16'd1);
      check("rdy_to_flag", 16'(SDC_Fault), 16'd1);

      // Heartbeat stops at CLOSING entry: after 10 silent cycles -> code 4.
      do_reset();
      enter_closing();
      repeat (HB) step(0, 1, 0, 0, 1, 0);
      check("hb_loss_before", 16'(State), 16'd2);
      step(0, 1, 0, 0, 1, 0);
      check("hb_loss_state", 16'(State), 16'd4);
      check("hb_loss_code", 16'(Fault_Code), 16'd4);
      check("hb_loss_close_sdc", 16'(AS_close_SDC), 16'd0);

      // Relay timeout alone in CLOSING -> code 2.
      do_reset();
      enter_closing();
      repeat (CT - 1) step(1, 1, 0, 0, 1, 0);
      check("relay_to_before", 16'(State), 16'd2);
      step(1, 1, 0, 0, 1, 0);
      check("relay_to_code", 16'(Fault_Code), 16'd2);

      // Heartbeat loss and relay timeout on the same edge -> code 4 wins.
      do_reset();
      enter_closing();
      repeat (CT - 1 - HB) step(1, 1, 0, 0, 1, 0);
      repeat (HB) step(0, 1, 0, 0, 1, 0);
      check("coinc_before", 16'(State), 16'd2);
      step(0, 1, 0, 0, 1, 0);
      check("coinc_state", 16'(State), 16'd4);
      check("coinc_code", 16'(Fault_Code), 16'd4);

      // Reset asserted between edges in CLOSING: outputs drop immediately.
      do_reset();
      enter_closing();
      check("mid_rst_pre_state", 16'(State), 16'd2);
      check("mid_rst_pre_wd", 16'(Watchdog), 16'd1);
      check("mid_rst_pre_close", 16'(AS_close_SDC), 16'd1);
      #2;
      Power_on_Reset = 1'b1;
      #1;
      check("mid_rst_state", 16'(State), 16'd0);
      check("mid_rst_wd", 16'(Watchdog), 16'd0);
      check("mid_rst_close", 16'(AS_close_SDC), 16'd0);

      // Random phase against the model.
      do_reset();
      r_fb = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         r_hb    = ($urandom_range(0, 99) < 30);
         r_close = ($urandom_range(0, 99) < 85);
         r_open  = ($urandom_range(0, 99) < 3);
         r_clr   = ($urandom_range(0, 99) < 10);
         r_rdy   = ($urandom_range(0, 99) < 80);
         if ($urandom_range(0, 99) < 10) r_fb = ~r_fb;
         step(r_hb, r_close, r_open, r_clr, r_rdy, r_fb);
         exp_bundle = {3'(m_state), m_close, m_wd, m_fault, 3'(m_code)};
         act_bundle = {State, AS_close_SDC, Watchdog, SDC_Fault, Fault_Code};
         check($sformatf("rand_cyc%0d {st,csdc,wd,flt,code}", c),
               16'(act_bundle), 16'(exp_bundle));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/as_sdc_initiator.md
Name: as_sdc_initiator

Overview:
- Autonomous-system side of the shutdown-circuit (SDC) closing interface.
- Generates the toggling Watchdog feed from the AS computer heartbeat.
- Sequences the AS_close_SDC request once the SDC logic reports SDC_is_Ready, then supervises the relay feedback.
- Latches a fault code on any protocol violation; the EBS supervisor reads it.

Parameters:
- WD_HALF_PERIOD, 500: clk cycles per Watchdog half-period.
- HB_TIMEOUT, 2000: clk cycles without a heartbeat before the heartbeat is declared lost.
- READY_DEBOUNCE, 16: consecutive cycles SDC_is_Ready must be 1 before closing.
- CLOSE_TIMEOUT, 1000: maximum cycles allowed in WAIT_READY or in CLOSING.
- CNT_W, 16: width of all internal counters; must hold max(HB_TIMEOUT, CLOSE_TIMEOUT).

Ports:
- clk  in  1  system clock; all inputs synchronous to it.
- Power_on_Reset  in  1  reset, asynchronous, active-high.
- AS_Heartbeat  in  1  one-cycle pulse from the AS computer.
- AS_Close_Request  in  1  level; AS requests SDC closure.
- AS_Open_Request  in  1  level; AS requests return to IDLE.
- Fault_Clear  in  1  pulse; clears a latched fault.
- SDC_is_Ready  in  1  ready indication from the SDC logic.
- To_SDC_relais_fb  in  1  SDC relay drive feedback.
- Watchdog  out  1  watchdog square-wave feed.
- AS_close_SDC  out  1  close request to the SDC logic.
- State  out  3  current FSM state encoding.
- SDC_Fault  out  1  latched fault flag.
- Fault_Code  out  3  latched fault cause.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - State=IDLE(0); Watchdog=0, AS_close_SDC=0, SDC_Fault=0, Fault_Code=0.
  - All counters cleared, except hb_cnt, which is set to HB_TIMEOUT. The heartbeat is therefore not OK until the first pulse arrives.
- Heartbeat tracking:
  - hb_cnt loads 0 on any cycle with AS_Heartbeat=1; otherwise it increments, saturating at HB_TIMEOUT.
  - hb_ok = (hb_cnt < HB_TIMEOUT).
- Watchdog generation:
  - Runs only while hb_ok=1 and State!=FAULT.
  - wd_cnt counts 0..WD_HALF_PERIOD-1, then wraps to 0; Watchdog toggles on each wrap.
  - When not running: Watchdog=0 on the next edge and wd_cnt=0.
  - After a restart, the first rising Watchdog edge comes exactly WD_HALF_PERIOD cycles later.
- FSM states: IDLE=0, WAIT_READY=1, CLOSING=2, CLOSED=3, FAULT=4.
  - st_cnt clears on every state entry and increments, saturating, while in the state.
  - IDLE: AS_close_SDC=0. Goes to WAIT_READY when AS_Close_Request=1 and hb_ok=1.
  - WAIT_READY:
    - rdy_cnt increments while SDC_is_Ready=1 and clears when it is 0.
    - Goes to CLOSING on the cycle rdy_cnt=READY_DEBOUNCE-1 with SDC_is_Ready=1.
    - Goes to IDLE if AS_Close_Request=0.
    - Goes to FAULT with code 1 (ready timeout) when st_cnt reaches CLOSE_TIMEOUT-1.
  - CLOSING:
    - AS_close_SDC=1, asserted in the same cycle State reads 2.
    - Goes to CLOSED when To_SDC_relais_fb=1.
    - Goes to FAULT with code 2 (relay timeout) when st_cnt reaches CLOSE_TIMEOUT-1.
  - CLOSED:
    - AS_close_SDC=0; the SDC logic latches the close.
    - Goes to FAULT with code 3 if To_SDC_relais_fb=0 while AS_Open_Request=0.
  - FAULT:
    - SDC_Fault=1, AS_close_SDC=0, Watchdog held 0.
    - Goes to IDLE on Fault_Clear=1 with AS_Close_Request=0 and hb_ok=1. SDC_Fault and Fault_Code clear on that edge.
    - Fault_Clear is ignored in any other state.
- Any of WAIT_READY, CLOSING or CLOSED: hb_ok=0 goes to FAULT with code 4 (heartbeat lost).
- AS_Open_Request=1 in WAIT_READY, CLOSING or CLOSED goes to IDLE.
- Simultaneous-event priority, highest first:
  1. Reset.
  2. Heartbeat loss.
  3. Timeout or relay drop.
  4. AS_Open_Request.
  5. Normal progress.
- The first fault latched wins; Fault_Code does not change while in FAULT.
- All outputs are registered, with no combinational path from inputs to outputs. The close request has latency 1 cycle from the qualifying SDC_is_Ready sample to AS_close_SDC=1.
- Counters never wrap past their saturation values.

Test Plan:
(Parameters for all scenarios: WD_HALF_PERIOD=4, HB_TIMEOUT=10, READY_DEBOUNCE=3, CLOSE_TIMEOUT=20.)
- Reset, then heartbeat every 5 cycles -> Watchdog toggles every 4 cycles. First rise occurs 4 cycles after the first heartbeat, when hb_ok turns on.
- AS_Close_Request=1, SDC_is_Ready=1 held -> State 1, then 2 after 3 ready cycles with AS_close_SDC=1. To_SDC_relais_fb=1 -> State 3, AS_close_SDC=0.
- SDC_is_Ready pattern 1,1,0,1,1,1 in WAIT_READY -> CLOSING is entered only after the final three consecutive 1s. Ready held 0 for 20 cycles -> FAULT, Fault_Code=1.
- In CLOSED, drop To_SDC_relais_fb with AS_Open_Request=0 -> FAULT, Fault_Code=3, Watchdog=0 next cycle. Fault_Clear while AS_Close_Request=1 -> stays FAULT; Fault_Clear with AS_Close_Request=0 -> IDLE.
- Stop heartbeat in CLOSING for 10 cycles -> FAULT, Fault_Code=4. A relay timeout in the same cycle still yields code 4.
- Assert Power_on_Reset mid-CLOSING between clock edges -> AS_close_SDC, Watchdog and State drop to 0 immediately, without waiting for a clock edge.
